// File: rtl/alu_arbiter_mips.sv
// alu_arbiter_mips: shares one alu_mips between two requesters, holds the ALU inputs for
// ALU_LATENCY cycles and returns the tagged result. Define ALU_ARB_RR_EN for round-robin arbitration.
module alu_arbiter_mips #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op1,
  input  logic [1:0]       req0_op2,
  input  logic             req0_op3,
  input  logic             req0_signed,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op1,
  input  logic [1:0]       req1_op2,
  input  logic             req1_op3,
  input  logic             req1_signed,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_op1,
  output logic [1:0]       alu_op2,
  output logic             alu_op3,
  output logic             alu_signed,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_slt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_slt,
  output logic             busy
);

  // state | meaning
  // IDLE  | no operation in flight; the granted requester sees reqN_ready
  // EXEC  | ALU inputs held while cnt counts down the ALU latency
  // RESP  | result held on rsp_*, waiting for rsp_ready
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       grant0;
  logic       grant1;
  logic       can_accept;
  logic       accept;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= grant1;
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  assign can_accept = (state == ST_IDLE) & ~reset;
  assign req0_ready = can_accept & grant0;
  assign req1_ready = can_accept & grant1;
  assign accept     = can_accept & (grant0 | grant1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_op3    <= 1'b0;
      alu_signed <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_slt    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op1    <= grant1 ? req1_op1    : req0_op1;
            alu_op2    <= grant1 ? req1_op2    : req0_op2;
            alu_op3    <= grant1 ? req1_op3    : req0_op3;
            alu_signed <= grant1 ? req1_signed : req0_signed;
            alu_a      <= grant1 ? req1_a      : req0_a;
            alu_b      <= grant1 ? req1_b      : req0_b;
            rsp_id     <= grant1;
            cnt        <= CNT_LOAD;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_result <= alu_result;
            rsp_slt    <= alu_slt;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
